// File: rtl/shift_req_arbiter.sv
// Round-robin front end for a shared pipelined left-shifter: issues one op per cycle,
// tags each op with its requester id, and collects results in a credit-protected FIFO.
module shift_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 16,
  parameter int WIDTH_W    = 4,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH_W-1:0] req_width,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          sh_a,
  output logic [WIDTH_W-1:0]         sh_width,
  input  logic [DATA_W-1:0]          sh_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_W-1:0]          resp_data,
  output logic [ID_W-1:0]            resp_id,
  output logic                       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0]      w_a [NUM_REQ];
  logic [WIDTH_W-1:0]     w_w [NUM_REQ];

  logic [ID_W-1:0]        r_ptr;
  logic [CW-1:0]          r_used;
  logic [DATA_W-1:0]      r_sh_a;
  logic [WIDTH_W-1:0]     r_sh_w;
  logic [LAT:0]           r_tag_v;
  logic [ID_W-1:0]        r_tag_id [0:LAT];

  logic [ID_W+DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;
  logic [CW-1:0]          r_cnt;

  logic                   w_found;
  logic [ID_W-1:0]        w_gnt_idx;
  logic [ID_W-1:0]        w_scan;
  logic                   w_credit_ok;
  logic                   w_xfer;
  logic                   w_push;
  logic                   w_pop;
  logic [ID_W+DATA_W-1:0] w_head;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a[gi] = req_a[gi*DATA_W +: DATA_W];
      assign w_w[gi] = req_width[gi*WIDTH_W +: WIDTH_W];
    end
  endgenerate

  // Credit check uses the registered count, so a pop frees a slot only next cycle.
  assign w_credit_ok = (r_used < CW'(FIFO_DEPTH));

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_xfer     = w_found && w_credit_ok;
  assign req_ready  = w_xfer ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign sh_a       = r_sh_a;
  assign sh_width   = r_sh_w;

  assign resp_valid = (r_cnt != '0);
  assign w_pop      = resp_valid && resp_ready;
  assign w_push     = r_tag_v[LAT];
  assign w_head     = r_mem[r_rd];
  assign resp_data  = resp_valid ? w_head[DATA_W-1:0] : '0;
  assign resp_id    = resp_valid ? w_head[ID_W+DATA_W-1:DATA_W] : '0;
  assign busy       = (r_used != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= ID_W'(NUM_REQ - 1);
      r_used  <= '0;
      r_sh_a  <= '0;
      r_sh_w  <= '0;
      r_tag_v <= '0;
      for (int k = 0; k <= LAT; k++) r_tag_id[k] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr  <= w_gnt_idx;
        r_sh_a <= w_a[w_gnt_idx];
        r_sh_w <= w_w[w_gnt_idx];
      end
      // Stage LAT lines up with the shifter output sh_b.
      r_tag_v     <= {r_tag_v[LAT-1:0], w_xfer};
      r_tag_id[0] <= w_gnt_idx;
      for (int k = 1; k <= LAT; k++) r_tag_id[k] <= r_tag_id[k-1];

      case ({w_xfer, w_pop})
        2'b10:   r_used <= r_used + CW'(1);
        2'b01:   r_used <= r_used - CW'(1);
        default: r_used <= r_used;
      endcase

      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {r_tag_id[LAT], sh_b};
  end

endmodule
